// File: rtl/pll_rst_seq.sv
// pll_rst_seq: reset sequencer for the pll0 clock wrapper, running on the board reference clock
// Ports:
//   clk          board reference clock (same net as pll0 refclk)
//   rst_n        asynchronous active-low power-on reset
//   btn_rst_n    raw push-button reset, active low, asynchronous and bouncy
//   sw_rst_req   software/debug reset request level, rising edge restarts the sequence
//   pll_reset_o  active-high reset to pll0
//   sys_rst_n_o  registered active-low SoC reset request, synchronous to clk only
//   busy_o       high whenever the sequencer is not in RUN
//   state_o      0=PLL_RST 1=PLL_WAIT 2=RUN
module pll_rst_seq #(
    parameter int PLL_RST_CYCLES   = 240,
    parameter int LOCK_WAIT_CYCLES = 24000,
    parameter int DEBOUNCE_CYCLES  = 240000,
    parameter int CNT_W            = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_rst_n,
    input  logic       sw_rst_req,
    output logic       pll_reset_o,
    output logic       sys_rst_n_o,
    output logic       busy_o,
    output logic [1:0] state_o
);
    typedef enum logic [1:0] {
        PLL_RST  = 2'd0,
        PLL_WAIT = 2'd1,
        RUN      = 2'd2,
        ILLEGAL  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(LOCK_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_s1, btn_s2;
    logic             sw_s1, sw_s2, sw_d;
    logic [CNT_W-1:0] deb_cnt;
    logic             btn_press, sw_evt, restart;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             pll_reset_nx, sys_rst_n_nx, busy_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= 1'b1;
            btn_s2 <= 1'b1;
            sw_s1  <= 1'b0;
            sw_s2  <= 1'b0;
            sw_d   <= 1'b0;
        end else begin
            btn_s1 <= btn_rst_n;
            btn_s2 <= btn_s1;
            sw_s1  <= sw_rst_req;
            sw_s2  <= sw_s1;
            sw_d   <= sw_s2;
        end
    end

    // deb_cnt counts earlier consecutive low samples and saturates at DEBOUNCE_CYCLES-1,
    // so the current low sample completes the run and asserts btn_press without an extra cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            deb_cnt <= '0;
        else
            deb_cnt <= btn_s2 ? '0 : (deb_cnt == DEB_LAST ? deb_cnt : deb_cnt + 1'b1);
    end

    assign btn_press = !btn_s2 && deb_cnt == DEB_LAST;
    assign sw_evt    = sw_s2 && !sw_d;
    assign restart   = btn_press || sw_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= PLL_RST;
            cnt         <= '0;
            pll_reset_o <= 1'b1;
            sys_rst_n_o <= 1'b0;
            busy_o      <= 1'b1;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            pll_reset_o <= pll_reset_nx;
            sys_rst_n_o <= sys_rst_n_nx;
            busy_o      <= busy_nx;
        end
    end

    // restart has priority over count completion; the illegal encoding falls back to PLL_RST
    always_comb begin
        state_nx = PLL_RST;
        cnt_nx   = '0;
        if (!restart) begin
            case (state)
                PLL_RST: begin
                    state_nx = cnt == RST_LAST ? PLL_WAIT : PLL_RST;
                    cnt_nx   = cnt == RST_LAST ? '0 : cnt + 1'b1;
                end
                PLL_WAIT: begin
                    state_nx = cnt == WAIT_LAST ? RUN : PLL_WAIT;
                    cnt_nx   = cnt == WAIT_LAST ? '0 : cnt + 1'b1;
                end
                RUN:     state_nx = RUN;
                default: state_nx = PLL_RST;
            endcase
        end
    end

    // outputs are decoded from the next state so they register on the same edge as the state
    always_comb begin
        pll_reset_nx = state_nx == PLL_RST;
        sys_rst_n_nx = state_nx == RUN;
        busy_nx      = state_nx != RUN;
    end

    assign state_o = state;
endmodule

// File: tb/tb_pll_rst_seq.sv
// tb_pll_rst_seq: randomized and directed bench for pll_rst_seq against an elapsed-time model
module tb_pll_rst_seq;
    localparam int P = 4;
    localparam int L = 8;
    localparam int D = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn_rst_n = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic       pll_reset_o, sys_rst_n_o, busy_o;
    logic [1:0] state_o;
    int         checks = 0;
    int         errors = 0;
    int         n;

    always #5 clk = ~clk;

    pll_rst_seq #(
        .PLL_RST_CYCLES(P),
        .LOCK_WAIT_CYCLES(L),
        .DEBOUNCE_CYCLES(D),
        .CNT_W(18)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_rst_n(btn_rst_n),
        .sw_rst_req(sw_rst_req),
        .pll_reset_o(pll_reset_o),
        .sys_rst_n_o(sys_rst_n_o),
        .busy_o(busy_o),
        .state_o(state_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // model: t = clock edges elapsed since the sequence (re)started, saturating once in RUN;
    // lowrun = length of the current run of low synchronized button samples
    int   m_t, lowrun;
    logic bs1, bs2, ss1, ss2, ss3;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t    <= 0;
            lowrun <= 0;
            bs1    <= 1'b1;
            bs2    <= 1'b1;
            ss1    <= 1'b0;
            ss2    <= 1'b0;
            ss3    <= 1'b0;
        end else begin
            m_t    <= (lowrun >= D || (ss2 && !ss3)) ? 0 : (m_t < P + L ? m_t + 1 : m_t);
            bs1    <= btn_rst_n;
            bs2    <= bs1;
            lowrun <= bs1 ? 0 : (lowrun < 1000 ? lowrun + 1 : lowrun);
            ss1    <= sw_rst_req;
            ss2    <= ss1;
            ss3    <= ss2;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("state", 32'(state_o), m_t < P ? 0 : (m_t < P + L ? 1 : 2));
            chk("pll_reset", 32'(pll_reset_o), m_t < P ? 1 : 0);
            chk("sys_rst_n", 32'(sys_rst_n_o), m_t >= P + L ? 1 : 0);
            chk("busy", 32'(busy_o), m_t < P + L ? 1 : 0);
        end
    end

    function automatic logic pick(input int which);
        return which == 0 ? pll_reset_o : (which == 1 ? sys_rst_n_o : (state_o == 2'd0));
    endfunction

    // edges from now until the selected signal reaches val, -1 if it never does
    task automatic count_to(input int which, input logic val, output int cnt);
        cnt = -1;
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk);
            #1;
            if (pick(which) == val) begin
                cnt = i;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pll"}, 32'(pll_reset_o), 1);
        chk({tag, "_sys"}, 32'(sys_rst_n_o), 0);
        chk({tag, "_busy"}, 32'(busy_o), 1);
        chk({tag, "_state"}, 32'(state_o), 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("por");
        @(negedge clk);
        chk_reset_outputs("por_held");
        rst_n = 1'b1;
        count_to(0, 1'b0, n);
        chk("pll_fall_edge", n, P);
        count_to(1, 1'b1, n);
        chk("sys_rise_after_fall", n, L);
        chk("run_state", 32'(state_o), 2);
        repeat (3) @(negedge clk);

        btn_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        btn_rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("short_btn_ignored", 32'(state_o), 2);

        btn_rst_n = 1'b0;
        count_to(2, 1'b1, n);
        chk("btn_latency", n, 2 + D);
        repeat (4) @(negedge clk);
        chk("btn_held_state", 32'(state_o), 0);
        btn_rst_n = 1'b1;
        count_to(1, 1'b1, n);
        chk("btn_release_to_sys", n, 2 + P + L);

        sw_rst_req = 1'b1;
        count_to(2, 1'b1, n);
        chk("sw_latency", n, 3);
        count_to(1, 1'b1, n);
        chk("sw_seq_len", n, P + L);
        repeat (14) @(negedge clk);
        chk("sw_held_no_retrigger", 32'(state_o), 2);
        sw_rst_req = 1'b0;
        repeat (3) @(negedge clk);

        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
        repeat (10) @(negedge clk);
        sw_rst_req = 1'b1;
        count_to(2, 1'b1, n);
        chk("sw_in_wait_latency", n, 3);
        count_to(1, 1'b1, n);
        chk("sw_in_wait_restart", n, P + L);
        sw_rst_req = 1'b0;
        repeat (3) @(negedge clk);

        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
        @(negedge clk);
        btn_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        sw_rst_req = 1'b1;
        repeat (8) @(negedge clk);
        chk("both_held_state", 32'(state_o), 0);
        btn_rst_n = 1'b1;
        count_to(1, 1'b1, n);
        chk("both_release_to_sys", n, 2 + P + L);
        sw_rst_req = 1'b0;
        repeat (3) @(negedge clk);

        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async_mid_run");
        @(negedge clk);
        rst_n = 1'b1;
        count_to(1, 1'b1, n);
        chk("por2_sys_rise", n, P + L);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (btn_rst_n ? $urandom_range(0, 24) == 0 : $urandom_range(0, 2) == 0)
                btn_rst_n = ~btn_rst_n;
            if ($urandom_range(0, 19) == 0)
                sw_rst_req = ~sw_rst_req;
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
